// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: decodes command frames arriving byte by byte from the UART
// receive path and turns them into register-file and ALU strobes. A frame
// that stalls between bytes for TIMEOUT_CYCLES cycles is aborted. Every
// output, including the debug state, comes straight from a register.
//
// Byte handshake: RX_D_VLD is a one-cycle strobe that qualifies RX_P_DATA.
// There is no back-pressure (no ready). Every strobed byte is consumed in the
// cycle it is presented. It is either used by the current frame or dropped
// with a one-cycle CMD_ERR pulse. RESP_DONE is likewise a one-cycle strobe,
// and it is only honoured while a response is pending.
module cmd_frame_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic                  RESP_DONE,
   output logic                  RF_WrEn,
   output logic                  RF_RdEn,
   output logic [ADDR_WIDTH-1:0] RF_Address,
   output logic [DATA_WIDTH-1:0] RF_WrData,
   output logic                  ALU_EN,
   output logic [3:0]            ALU_FUN,
   output logic                  CLK_GATE_EN,
   output logic                  RESP_SRC,
   output logic                  CMD_ERR,
   output logic [2:0]            dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WR_ADDR   = 3'd1,
      S_WR_DATA   = 3'd2,
      S_RD_ADDR   = 3'd3,
      S_OP_A      = 3'd4,
      S_OP_B      = 3'd5,
      S_ALU_FUN   = 3'd6,
      S_WAIT_RESP = 3'd7
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);
   // The abort fires on the cycle in which the idle count would reach TIMEOUT_CYCLES.
   localparam logic [15:0]           TO_LAST     = 16'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_n;
   logic [15:0]             cnt_q, cnt_n;
   logic                    wr_en_n, rd_en_n, alu_en_n, err_n, gate_n, src_n;
   logic [ADDR_WIDTH-1:0]   addr_n;
   logic [DATA_WIDTH-1:0]   wdata_n;
   logic [3:0]              fun_n;
   logic                    in_frame;
   logic                    timeout;

   // Only partially received frames are subject to the inter-byte timeout.
   assign in_frame = (state_q != S_IDLE) && (state_q != S_WAIT_RESP);
   assign timeout  = in_frame && !RX_D_VLD && (cnt_q == TO_LAST);
   assign dbg_state = state_q;

   // State, timeout counter and every output register. Reset clears all of them at once.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         RF_WrEn     <= 1'b0;
         RF_RdEn     <= 1'b0;
         RF_Address  <= '0;
         RF_WrData   <= '0;
         ALU_EN      <= 1'b0;
         ALU_FUN     <= '0;
         CLK_GATE_EN <= 1'b0;
         RESP_SRC    <= 1'b0;
         CMD_ERR     <= 1'b0;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         RF_WrEn     <= wr_en_n;
         RF_RdEn     <= rd_en_n;
         RF_Address  <= addr_n;
         RF_WrData   <= wdata_n;
         ALU_EN      <= alu_en_n;
         ALU_FUN     <= fun_n;
         CLK_GATE_EN <= gate_n;
         RESP_SRC    <= src_n;
         CMD_ERR     <= err_n;
      end
   end

   // Next state and next register values. Strobes default low; the rest hold their value.
   always_comb begin
      state_n  = state_q;
      cnt_n    = '0;
      wr_en_n  = 1'b0;
      rd_en_n  = 1'b0;
      alu_en_n = 1'b0;
      err_n    = 1'b0;
      addr_n   = RF_Address;
      wdata_n  = RF_WrData;
      fun_n    = ALU_FUN;
      gate_n   = CLK_GATE_EN;
      src_n    = RESP_SRC;

      if (in_frame && !RX_D_VLD)
         cnt_n = cnt_q + 16'd1;

      if (timeout) begin
         // Abandon the partial frame without issuing any RF or ALU strobe.
         state_n = S_IDLE;
         cnt_n   = '0;
         err_n   = 1'b1;
         gate_n  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == CMD_WR) begin
                     state_n = S_WR_ADDR;
                  end else if (RX_P_DATA == CMD_RD) begin
                     state_n = S_RD_ADDR;
                  end else if (RX_P_DATA == CMD_ALU_OP) begin
                     state_n = S_OP_A;
                     gate_n  = 1'b1;
                  end else if (RX_P_DATA == CMD_ALU_NOP) begin
                     state_n = S_ALU_FUN;
                     gate_n  = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
               end
            end
            S_WR_ADDR: begin
               if (RX_D_VLD) begin
                  addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                  state_n = S_WR_DATA;
               end
            end
            S_WR_DATA: begin
               if (RX_D_VLD) begin
                  wdata_n = RX_P_DATA;
                  wr_en_n = 1'b1;
                  state_n = S_IDLE;
               end
            end
            S_RD_ADDR: begin
               if (RX_D_VLD) begin
                  addr_n  = RX_P_DATA[ADDR_WIDTH-1:0];
                  rd_en_n = 1'b1;
                  src_n   = 1'b0;
                  state_n = S_WAIT_RESP;
               end
            end
            S_OP_A: begin
               if (RX_D_VLD) begin
                  addr_n  = '0;
                  wdata_n = RX_P_DATA;
                  wr_en_n = 1'b1;
                  state_n = S_OP_B;
               end
            end
            S_OP_B: begin
               if (RX_D_VLD) begin
                  addr_n  = ADDR_WIDTH'(1);
                  wdata_n = RX_P_DATA;
                  wr_en_n = 1'b1;
                  state_n = S_ALU_FUN;
               end
            end
            S_ALU_FUN: begin
               if (RX_D_VLD) begin
                  fun_n    = RX_P_DATA[3:0];
                  alu_en_n = 1'b1;
                  src_n    = 1'b1;
                  state_n  = S_WAIT_RESP;
               end
            end
            S_WAIT_RESP: begin
               // No new frame may start while a response is pending.
               if (RX_D_VLD)
                  err_n = 1'b1;
               if (RESP_DONE) begin
                  gate_n  = 1'b0;
                  state_n = S_IDLE;
               end
            end
            default: begin
               state_n = S_IDLE;
               gate_n  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Bench for cmd_frame_ctrl. Drivers issue directed frames and push the strobe
// each frame should produce into exp_q. A monitor pops and compares whenever
// the DUT raises a strobe. Direct checks cover reset and the level outputs.
module tb_cmd_frame_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int TO = 16;
   localparam int W  = 32;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] RX_P_DATA = '0;
   logic          RX_D_VLD = 1'b0;
   logic          RESP_DONE = 1'b0;
   logic          RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, RESP_SRC, CMD_ERR;
   logic [AW-1:0] RF_Address;
   logic [DW-1:0] RF_WrData;
   logic [3:0]    ALU_FUN;
   logic [2:0]    dbg_state;

   logic [W-1:0]  exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;

   cmd_frame_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RESP_DONE(RESP_DONE), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
      .RF_Address(RF_Address), .RF_WrData(RF_WrData), .ALU_EN(ALU_EN),
      .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN), .RESP_SRC(RESP_SRC),
      .CMD_ERR(CMD_ERR), .dbg_state(dbg_state)
   );

   // Clock: 10 time-unit period.
   always #5 CLK = ~CLK;

   // Event word: {wr,rd,alu,err, addr, data, fun, src, gate}. A field is kept only for the strobe it belongs to.
   function automatic logic [W-1:0] pack(logic wr, logic rd, logic alu, logic err,
                                         logic [AW-1:0] a, logic [DW-1:0] d,
                                         logic [3:0] f, logic s, logic g);
      logic [AW-1:0] a_m;
      logic [DW-1:0] d_m;
      logic [3:0]    f_m;
      logic          s_m;
      a_m = (wr | rd) ? a : '0;
      d_m = wr ? d : '0;
      f_m = alu ? f : 4'h0;
      s_m = (rd | alu) ? s : 1'b0;
      return W'({wr, rd, alu, err, a_m, d_m, f_m, s_m, g});
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic g);
      exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, a, d, 4'h0, 1'b0, g));
   endtask
   task automatic exp_rd(input logic [AW-1:0] a, input logic g);
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, a, '0, 4'h0, 1'b0, g));
   endtask
   task automatic exp_alu(input logic [3:0] f, input logic g);
      exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, f, 1'b1, g));
   endtask
   task automatic exp_err(input logic g);
      exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, 4'h0, 1'b0, g));
   endtask

   // Driver: one strobed byte, then `gap` quiet cycles.
   task automatic send_byte(input logic [DW-1:0] b, input int gap);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      repeat (gap) @(negedge CLK);
   endtask

   task automatic resp_done(input logic with_byte, input logic [DW-1:0] b);
      @(negedge CLK);
      RESP_DONE = 1'b1;
      RX_D_VLD  = with_byte;
      RX_P_DATA = b;
      @(negedge CLK);
      RESP_DONE = 1'b0;
      RX_D_VLD  = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check(name, W'({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN,
                      CLK_GATE_EN, RESP_SRC, CMD_ERR}), '0);
   endtask

   // Monitor: every strobe cycle must match the oldest expected event.
   always @(negedge CLK) begin
      logic [W-1:0] act;
      logic [W-1:0] req;
      if (RST && (RF_WrEn || RF_RdEn || ALU_EN || CMD_ERR)) begin
         act = pack(RF_WrEn, RF_RdEn, ALU_EN, CMD_ERR, RF_Address, RF_WrData,
                    ALU_FUN, RESP_SRC, CLK_GATE_EN);
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe actual=%h required=none", act);
         end else begin
            req = exp_q.pop_front();
            check("strobe", act, req);
         end
      end
   end

   // Stimulus sequence.
   initial begin
      // Reset: outputs must be 0 while RST is low.
      repeat (3) @(negedge CLK);
      check_all_zero("reset_outputs");
      check("reset_state", W'(dbg_state), W'(3'd0));
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check_all_zero("post_reset_outputs");

      // RF write: AA 05 D2.
      exp_wr(4'd5, 8'hD2, 1'b0);
      send_byte(8'hAA, 1);
      send_byte(8'h05, 2);
      send_byte(8'hD2, 2);

      // RF read: BB 05, then a stray AA while waiting, then RESP_DONE.
      exp_rd(4'd5, 1'b0);
      send_byte(8'hBB, 0);
      send_byte(8'h05, 1);
      check("rd_wait_state", W'(dbg_state), W'(3'd7));
      exp_err(1'b0);
      send_byte(8'hAA, 2);
      resp_done(1'b0, 8'h00);
      check("rd_done_idle", W'(dbg_state), W'(3'd0));

      // ALU with operands: CC AD 81 00.
      exp_wr(4'd0, 8'hAD, 1'b1);
      exp_wr(4'd1, 8'h81, 1'b1);
      exp_alu(4'h0, 1'b1);
      send_byte(8'hCC, 1);
      check("gate_on_op_a", W'(CLK_GATE_EN), W'(1'b1));
      send_byte(8'hAD, 1);
      send_byte(8'h81, 1);
      send_byte(8'h00, 3);
      check("gate_held", W'({CLK_GATE_EN, RESP_SRC}), W'(2'b11));
      resp_done(1'b0, 8'h00);
      check("gate_off_done", W'({CLK_GATE_EN, dbg_state}), W'(4'b0000));

      // ALU without operands: DD F3. RESP_DONE coincides with a byte.
      exp_alu(4'h3, 1'b1);
      send_byte(8'hDD, 1);
      send_byte(8'hF3, 2);
      exp_err(1'b0);
      resp_done(1'b1, 8'h42);
      check("dd_done_idle", W'(dbg_state), W'(3'd0));

      // Illegal command byte in IDLE.
      exp_err(1'b0);
      send_byte(8'h55, 2);

      // Timeout after AA, then a normal write.
      exp_err(1'b0);
      send_byte(8'hAA, TO + 4);
      check("timeout_idle", W'(dbg_state), W'(3'd0));
      exp_wr(4'd2, 8'h81, 1'b0);
      send_byte(8'hAA, 0);
      send_byte(8'h02, 0);
      send_byte(8'h81, 2);

      // Mid-frame reset after CC AD.
      exp_wr(4'd0, 8'hAD, 1'b1);
      send_byte(8'hCC, 0);
      send_byte(8'hAD, 0);
      check("gate_before_rst", W'(CLK_GATE_EN), W'(1'b1));
      #2 RST = 1'b0;
      #1 check_all_zero("async_reset_outputs");
      check("async_reset_state", W'(dbg_state), W'(3'd0));
      @(negedge CLK);
      RST = 1'b1;
      exp_alu(4'h3, 1'b1);
      send_byte(8'hDD, 0);
      send_byte(8'hF3, 2);
      resp_done(1'b0, 8'h00);
      check("final_idle", W'({CLK_GATE_EN, dbg_state}), W'(4'b0000));

      repeat (5) @(negedge CLK);
      check("queue_empty", W'(exp_q.size()), W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cmd_frame_ctrl.md
CMD_FRAME_CTRL -- requirements
Module: cmd_frame_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width of received frames.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 65535, idle CLK cycles allowed between bytes of one frame (16-bit counter).
REQ-004 SHALL have port CLK  input  1  reference clock; all logic on the rising edge; one clock only.
REQ-005 SHALL have port RST  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port RX_P_DATA  input  DATA_WIDTH  synchronized byte from the UART receive path.
REQ-007 SHALL have port RX_D_VLD  input  1  one-cycle strobe qualifying RX_P_DATA.
REQ-008 SHALL have port RESP_DONE  input  1  one-cycle strobe from the transmit side: response fully sent.
REQ-009 SHALL have port RF_WrEn  output  1  register-file write strobe.
REQ-010 SHALL have port RF_RdEn  output  1  register-file read strobe.
REQ-011 SHALL have port RF_Address  output  ADDR_WIDTH  register-file address.
REQ-012 SHALL have port RF_WrData  output  DATA_WIDTH  register-file write data.
REQ-013 SHALL have port ALU_EN  output  1  ALU start strobe.
REQ-014 SHALL have port ALU_FUN  output  4  ALU function code.
REQ-015 SHALL have port CLK_GATE_EN  output  1  ALU clock-gate enable.
REQ-016 SHALL have port RESP_SRC  output  1  pending response source: 0 = RF read, 1 = ALU.
REQ-017 SHALL have port CMD_ERR  output  1  one-cycle error strobe.

Function
REQ-018 SHALL decode command bytes: 0xAA RF write, 0xBB RF read, 0xCC ALU with operands, 0xDD ALU without operands.
REQ-019 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN, WAIT_RESP.
REQ-020 SHALL make the following transitions from IDLE on a strobed byte: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OP_A, 0xDD->ALU_FUN.
REQ-021 SHALL pulse CMD_ERR for one cycle and stay in IDLE on any other byte in IDLE.
REQ-022 SHALL, on a byte in WR_ADDR, latch RF_Address = byte[ADDR_WIDTH-1:0] and go to WR_DATA.
REQ-023 SHALL, on a byte in WR_DATA, drive RF_WrData = byte and RF_WrEn = 1 for exactly one cycle, starting the cycle after the strobe, then go to IDLE.
REQ-024 SHALL, on a byte in RD_ADDR, drive RF_Address and pulse RF_RdEn for one cycle the cycle after the strobe, set RESP_SRC = 0, and go to WAIT_RESP.
REQ-025 SHALL, on a byte in OP_A, pulse RF_WrEn with address 0 and data = byte, then go to OP_B.
REQ-026 SHALL, on a byte in OP_B, pulse RF_WrEn with address 1 and data = byte, then go to ALU_FUN.
REQ-027 SHALL set CLK_GATE_EN = 1 on entry to OP_A or ALU_FUN and hold it until RESP_DONE is received in WAIT_RESP, or until abort.
REQ-028 SHALL, on a byte in ALU_FUN, set ALU_FUN = byte[3:0] (upper bits ignored), pulse ALU_EN for one cycle the cycle after the strobe, set RESP_SRC = 1, and go to WAIT_RESP.
REQ-029 SHALL drop any byte received in WAIT_RESP and pulse CMD_ERR for it.
REQ-030 SHALL go from WAIT_RESP to IDLE on RESP_DONE; if RX_D_VLD coincides, the byte is dropped with a CMD_ERR pulse.
REQ-031 SHALL ignore RESP_DONE in every state other than WAIT_RESP.
REQ-032 SHALL clear the timeout counter on every strobed byte and count CLK cycles in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN.
REQ-033 SHALL, when the counter reaches TIMEOUT_CYCLES, pulse CMD_ERR, clear CLK_GATE_EN, and go to IDLE with no RF or ALU strobe.
REQ-034 SHALL never time out in IDLE or WAIT_RESP.
REQ-035 SHALL drive all outputs from registers, and never assert RF_WrEn and RF_RdEn in the same cycle.

Reset
REQ-036 SHALL, while RST = 0, force state IDLE, zero the counter, and drive all outputs to 0; this applies immediately, including mid-frame.
REQ-037 SHALL, after RST deasserts, treat the first byte as a command byte.

Verification
REQ-038 SHALL verify: bytes AA,05,D2 -> one RF_WrEn cycle with RF_Address = 5 and RF_WrData = 0xD2; CMD_ERR stays 0.
REQ-039 SHALL verify: bytes BB,05 -> one RF_RdEn cycle with RF_Address = 5 and RESP_SRC = 0; a following byte 0xAA before RESP_DONE -> CMD_ERR pulse; after RESP_DONE, state is IDLE.
REQ-040 SHALL verify: bytes CC,AD,81,00 -> writes (addr 0, 0xAD) then (addr 1, 0x81); then ALU_EN with ALU_FUN = 0, RESP_SRC = 1, CLK_GATE_EN = 1 until RESP_DONE.
REQ-041 SHALL verify: bytes DD,F3 -> no RF_WrEn; ALU_EN with ALU_FUN = 3.
REQ-042 SHALL verify: byte 0x55 in IDLE -> CMD_ERR pulse and no strobes; byte 0xAA then silence of TIMEOUT_CYCLES -> CMD_ERR pulse and IDLE; a following AA,02,81 -> normal write.
REQ-043 SHALL verify: bytes CC,AD then RST low for 1 cycle -> all outputs 0 at once, CLK_GATE_EN = 0; next byte DD is accepted as a command.
